// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bus: two requesters (ALU, load return), the
// registered write port, and the read-address bypass compare.
interface regfile_write_arbiter_if;
  logic        aluValid;
  logic [4:0]  aluAddr;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic        memReady;
  logic        writeEnable;
  logic [4:0]  writeRegisterAddress;
  logic [31:0] writeRegisterData;
  logic [4:0]  readRegisterAddress1;
  logic [4:0]  readRegisterAddress2;
  logic        fwdHit1;
  logic        fwdHit2;
  logic [31:0] fwdData;
  logic [7:0]  stallCount;

  // Requester / pipeline side
  modport master (
    output aluValid, aluAddr, aluData, memValid, memAddr, memData,
           readRegisterAddress1, readRegisterAddress2,
    input  aluReady, memReady, writeEnable, writeRegisterAddress,
           writeRegisterData, fwdHit1, fwdHit2, fwdData, stallCount
  );

  // Arbiter side
  modport slave (
    input  aluValid, aluAddr, aluData, memValid, memAddr, memData,
           readRegisterAddress1, readRegisterAddress2,
    output aluReady, memReady, writeEnable, writeRegisterAddress,
           writeRegisterData, fwdHit1, fwdHit2, fwdData, stallCount
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for a single register-file write port.
// One write per cycle, 1-cycle latency, register 0 never written, bypass
// compare on the issuing write, saturating count of denied cycles.
module regfile_write_arbiter (
  input  logic                      clk,
  input  logic                      rstd,
  regfile_write_arbiter_if.slave    bus
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

  grant_e      r_lastConflictGrant;
  logic        r_writeEnable;
  logic [4:0]  r_writeAddr;
  logic [31:0] r_writeData;
  logic [7:0]  r_stallCount;

  logic        w_conflict;
  logic        w_aluReady;
  logic        w_memReady;
  logic        w_aluFire;
  logic        w_memFire;
  logic        w_fire;
  logic        w_denied;
  logic [4:0]  w_selAddr;
  logic [31:0] w_selData;

  // Ready depends only on the valids and the pointer; outside a conflict
  // every requester is accepted, so both readies sit high.
  assign w_conflict = bus.aluValid & bus.memValid;
  assign w_aluReady = ~w_conflict | (r_lastConflictGrant == GRANT_MEM);
  assign w_memReady = ~w_conflict | (r_lastConflictGrant == GRANT_ALU);

  assign w_aluFire  = bus.aluValid & w_aluReady;
  assign w_memFire  = bus.memValid & w_memReady;
  assign w_fire     = w_aluFire | w_memFire;
  assign w_denied   = (bus.aluValid & ~w_aluReady) | (bus.memValid & ~w_memReady);

  // At most one fire per cycle, so a simple select is enough.
  assign w_selAddr  = w_aluFire ? bus.aluAddr : bus.memAddr;
  assign w_selData  = w_aluFire ? bus.aluData : bus.memData;

  // Round-robin pointer: moves only when both requesters collide.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd)           r_lastConflictGrant <= GRANT_MEM;
    else if (w_conflict) r_lastConflictGrant <= (r_lastConflictGrant == GRANT_MEM) ? GRANT_ALU : GRANT_MEM;
  end

  // Write port: a transfer to r0 completes the handshake but issues nothing
  // and leaves the held address/data untouched.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_writeEnable <= 1'b0;
      r_writeAddr   <= 5'd0;
      r_writeData   <= 32'h0000_0000;
    end else if (w_fire && (w_selAddr != 5'd0)) begin
      r_writeEnable <= 1'b1;
      r_writeAddr   <= w_selAddr;
      r_writeData   <= w_selData;
    end else begin
      r_writeEnable <= 1'b0;
    end
  end

  // Saturating count of cycles in which some requester was turned away.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd)                                r_stallCount <= 8'h00;
    else if (w_denied && r_stallCount != 8'hFF) r_stallCount <= r_stallCount + 8'd1;
  end

  // Bypass: a read of the register being written this cycle takes the new value.
  always_comb begin
    bus.fwdHit1 = r_writeEnable && (r_writeAddr == bus.readRegisterAddress1) &&
                  (bus.readRegisterAddress1 != 5'd0);
    bus.fwdHit2 = r_writeEnable && (r_writeAddr == bus.readRegisterAddress2) &&
                  (bus.readRegisterAddress2 != 5'd0);
  end

  assign bus.aluReady             = w_aluReady;
  assign bus.memReady             = w_memReady;
  assign bus.writeEnable          = r_writeEnable;
  assign bus.writeRegisterAddress = r_writeAddr;
  assign bus.writeRegisterData    = r_writeData;
  assign bus.fwdData              = r_writeData;
  assign bus.stallCount           = r_stallCount;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk (rising edge) and rstd (0 = reset).
REQ-002 Ports SHALL be, one per line, as name  direction  width  meaning:
  clk  in  1  system clock
  rstd  in  1  async active-low reset
  aluValid  in  1  ALU requester has a write pending
  aluAddr  in  5  ALU destination register
  aluData  in  32  ALU write data
  aluReady  out  1  ALU request accepted this cycle (combinational)
  memValid  in  1  load-return requester has a write pending
  memAddr  in  5  load destination register
  memData  in  32  load write data
  memReady  out  1  load request accepted this cycle (combinational)
  writeEnable  out  1  register-file write strobe (registered)
  writeRegisterAddress  out  5  register-file write address (registered)
  writeRegisterData  out  32  register-file write data (registered)
  readRegisterAddress1  in  5  read port 1 address, for bypass compare
  readRegisterAddress2  in  5  read port 2 address, for bypass compare
  fwdHit1  out  1  read port 1 must take fwdData
  fwdHit2  out  1  read port 2 must take fwdData
  fwdData  out  32  bypass value, equal to writeRegisterData
  stallCount  out  8  saturating count of denied request cycles

Function
REQ-003 A transfer SHALL occur on a rising clk edge when xValid and xReady are both 1.
REQ-004 With exactly one requester valid, that requester's ready SHALL be 1.
REQ-005 With both requesters valid, exactly one ready SHALL be 1, chosen round-robin: grant goes to the requester not granted at the last conflict.
REQ-006 The round-robin pointer lastConflictGrant SHALL update only on conflict cycles; non-conflict grants SHALL leave it unchanged.
REQ-007 With neither requester valid, both readies SHALL be 1 and no state SHALL change except writeEnable clearing.
REQ-008 A transfer accepted at edge N SHALL drive writeEnable=1 with the accepted address and data from edge N through edge N+1; latency is 1 cycle and one write per cycle is issued.
REQ-009 With no transfer at edge N, writeEnable SHALL be 0 after edge N; address and data SHALL hold their previous values.
REQ-010 A transfer to address 0 SHALL complete the handshake but SHALL leave writeEnable=0, so register 0 is never written.
REQ-011 Ready SHALL depend only on the two valid inputs and the pointer, never on the register-file state; aluReady and memReady SHALL never both be 1 while both valids are 1.
REQ-012 fwdHitK SHALL be 1 iff writeEnable=1, writeRegisterAddress==readRegisterAddressK and readRegisterAddressK!=0; this logic SHALL be combinational.
REQ-013 fwdData SHALL always equal writeRegisterData.
REQ-014 stallCount SHALL increment by 1 on each edge where a requester is valid but not ready, and SHALL saturate at 8'hFF without wrap.
REQ-015 Requester inputs SHALL be sampled only at the transfer edge; changes while not ready SHALL have no effect.

Reset
REQ-016 While rstd=0 the block SHALL force writeEnable=0, writeRegisterAddress=5'd0, writeRegisterData=32'h00000000, stallCount=8'h00 and lastConflictGrant=MEM, so the first conflict after reset grants ALU.
REQ-017 Reset SHALL act immediately regardless of clk; a transfer in flight SHALL be discarded without its write issuing.
REQ-018 Combinational readies during reset SHALL follow REQ-004 to REQ-007, but no transfer SHALL be recorded until rstd=1.

Verification
REQ-019 Single requester: aluValid=1, aluAddr=5, aluData=32'hDEADBEEF for one cycle -> aluReady=1, then writeEnable=1, address 5, data DEADBEEF for one cycle, then writeEnable=0.
REQ-020 Conflict sequence: both valid for 3 cycles (ALU addr 1, MEM addr 2) after reset -> grants ALU, MEM, ALU; memReady=0 on cycles 1 and 3; stallCount=3.
REQ-021 Zero register: memValid=1, memAddr=0, memData=32'h1 -> memReady=1, writeEnable remains 0.
REQ-022 Bypass: write to address 7 issuing, readRegisterAddress1=7, readRegisterAddress2=0 -> fwdHit1=1, fwdHit2=0, fwdData equals the write data.
REQ-023 Saturation and reset: 300 denied cycles -> stallCount=FF; rstd pulsed low mid-write -> writeEnable=0 and stallCount=00 immediately, before the next clk edge.
